// File: rtl/fifo_sync_param.sv
// Parametrised synchronous FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds, sticky overflow/underflow error flag
// and a registered read port with a one-cycle valid strobe.
module fifo_sync_param #(
    parameter int DATA_WIDTH = 10,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ADDR_WIDTH:0]   alto,
    input  logic [ADDR_WIDTH:0]   bajo,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  full_fifo,
    output logic                  empty_fifo,
    output logic                  almost_full_fifo,
    output logic                  almost_empty_fifo,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   fill_count
);

    localparam int Depth = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DepthC = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] OneC   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem_q [Depth];

    logic [ADDR_WIDTH-1:0] wrPtr_q, wrPtr_d;
    logic [ADDR_WIDTH-1:0] rdPtr_q, rdPtr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] dataOut_q, dataOut_d;
    logic                  dataValid_q, dataValid_d;
    logic                  error_q, error_d;

    logic wrOk;
    logic rdOk;
    logic overflow;
    logic underflow;

    // Status flags are decoded straight from the count register so they
    // track the occupancy after each edge and follow threshold changes.
    always_comb begin
        full_fifo         = (count_q == DepthC);
        empty_fifo        = (count_q == '0);
        almost_full_fifo  = (count_q >= alto);
        almost_empty_fifo = (count_q <= bajo);
    end

    // Accept rules: a push into a full FIFO rides on a simultaneous pop,
    // while a pop from an empty FIFO is always rejected.
    always_comb begin
        wrOk      = push & (~full_fifo | pop);
        rdOk      = pop & ~empty_fifo;
        overflow  = push & full_fifo & ~pop;
        underflow = pop & empty_fifo;
    end

    // Next-state computation for pointers, occupancy, read port and error.
    always_comb begin
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        count_d     = count_q;
        dataOut_d   = dataOut_q;
        dataValid_d = rdOk;
        error_d     = error_q;

        if (wrOk) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
        if (rdOk) begin
            rdPtr_d   = rdPtr_q + 1'b1;
            dataOut_d = mem_q[rdPtr_q];
        end

        case ({wrOk, rdOk})
            2'b10:   count_d = count_q + OneC;
            2'b01:   count_d = count_q - OneC;
            default: count_d = count_q;
        endcase

        if (overflow || underflow) begin
            error_d = 1'b1;
        end else if (err_clr) begin
            error_d = 1'b0;
        end
    end

    // Control state register; reset drops all contents immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
            dataOut_q   <= '0;
            dataValid_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            count_q     <= count_d;
            dataOut_q   <= dataOut_d;
            dataValid_q <= dataValid_d;
            error_q     <= error_d;
        end
    end

    // Storage array is not reset; emptiness is tracked by the count alone.
    always_ff @(posedge clk) begin
        if (wrOk) begin
            mem_q[wrPtr_q] <= data_in;
        end
    end

    assign data_out   = dataOut_q;
    assign data_valid = dataValid_q;
    assign error      = error_q;
    assign fill_count = count_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Self-checking bench for fifo_sync_param: a reference queue acts as the
// scoreboard, words are pushed into it as they are driven and popped out
// as the DUT reads them.
module tb_fifo_sync_param;

    localparam int DW = 10;
    localparam int AW = 3;
    localparam int DEPTH = 1 << AW;

    logic          clock;
    logic          reset;
    logic          push;
    logic          pop;
    logic [DW-1:0] dataIn;
    logic [AW:0]   alto;
    logic [AW:0]   bajo;
    logic          errClr;
    logic [DW-1:0] dataOut;
    logic          dataValid;
    logic          fullFifo;
    logic          emptyFifo;
    logic          almostFull;
    logic          almostEmpty;
    logic          errorFlag;
    logic [AW:0]   fillCount;

    int assertCount = 0;
    int failCount   = 0;

    logic [DW-1:0] sbQ[$];
    int            cntM;
    logic [DW-1:0] dataOutM;
    logic          dvM;
    logic          errM;

    fifo_sync_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk              (clock),
        .reset            (reset),
        .push             (push),
        .pop              (pop),
        .data_in          (dataIn),
        .alto             (alto),
        .bajo             (bajo),
        .err_clr          (errClr),
        .data_out         (dataOut),
        .data_valid       (dataValid),
        .full_fifo        (fullFifo),
        .empty_fifo       (emptyFifo),
        .almost_full_fifo (almostFull),
        .almost_empty_fifo(almostEmpty),
        .error            (errorFlag),
        .fill_count       (fillCount)
    );

    // Free-running 10-unit clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single comparison point: counts and reports every check.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Compares every DUT output against the reference model.
    task automatic checkState(input string tag);
        checkOutput({tag, ".fill"},    32'(fillCount),   32'(cntM));
        checkOutput({tag, ".empty"},   32'(emptyFifo),   32'(cntM == 0));
        checkOutput({tag, ".full"},    32'(fullFifo),    32'(cntM == DEPTH));
        checkOutput({tag, ".aFull"},   32'(almostFull),  32'(cntM >= int'(alto)));
        checkOutput({tag, ".aEmpty"},  32'(almostEmpty), 32'(cntM <= int'(bajo)));
        checkOutput({tag, ".error"},   32'(errorFlag),   32'(errM));
        checkOutput({tag, ".valid"},   32'(dataValid),   32'(dvM));
        checkOutput({tag, ".dataOut"}, 32'(dataOut),     32'(dataOutM));
    endtask

    // Drives one clock of stimulus, advances the model, then checks.
    task automatic applyStimulus(input string tag, input logic p, input logic q,
                                 input logic [DW-1:0] d, input logic ec);
        logic fullM, emptyM, wrM, rdM, errSet;
        @(negedge clock);
        push   = p;
        pop    = q;
        dataIn = d;
        errClr = ec;
        fullM  = (cntM == DEPTH);
        emptyM = (cntM == 0);
        wrM    = p & (~fullM | q);
        rdM    = q & ~emptyM;
        errSet = (p & fullM & ~q) | (q & emptyM);
        if (rdM) dataOutM = sbQ.pop_front();
        if (wrM) sbQ.push_back(d);
        cntM = sbQ.size();
        if (errSet) errM = 1'b1;
        else if (ec) errM = 1'b0;
        dvM = rdM;
        @(posedge clock);
        #1;
        checkState(tag);
    endtask

    task automatic resetModel();
        sbQ.delete();
        cntM     = 0;
        dataOutM = '0;
        dvM      = 1'b0;
        errM     = 1'b0;
    endtask

    initial begin
        push   = 1'b0;
        pop    = 1'b0;
        dataIn = '0;
        errClr = 1'b0;
        alto   = 4'd6;
        bajo   = 4'd2;
        reset  = 1'b1;
        resetModel();
        #1;
        $display("[TB] reset state");
        checkState("reset");
        @(negedge clock);
        reset = 1'b0;

        $display("[TB] fill to full and overflow");
        for (int i = 1; i <= DEPTH; i++) applyStimulus("fill", 1'b1, 1'b0, DW'(i), 1'b0);
        applyStimulus("overflow", 1'b1, 1'b0, 10'h3FF, 1'b0);

        $display("[TB] drain and underflow");
        for (int i = 1; i <= DEPTH; i++) applyStimulus("drain", 1'b0, 1'b1, '0, 1'b0);
        applyStimulus("underflow", 1'b0, 1'b1, '0, 1'b0);
        applyStimulus("idleErr", 1'b0, 1'b0, '0, 1'b0);
        applyStimulus("errClr", 1'b0, 1'b0, '0, 1'b1);

        $display("[TB] push+pop while full");
        for (int i = 0; i < DEPTH; i++) applyStimulus("refill", 1'b1, 1'b0, DW'(10'h100 + i), 1'b0);
        applyStimulus("fullPushPop", 1'b1, 1'b1, 10'h0AA, 1'b0);
        for (int i = 0; i < DEPTH; i++) applyStimulus("drainAA", 1'b0, 1'b1, '0, 1'b0);

        $display("[TB] push+pop while empty");
        applyStimulus("emptyPushPop", 1'b1, 1'b1, 10'h055, 1'b0);
        applyStimulus("pop55", 1'b0, 1'b1, '0, 1'b0);
        applyStimulus("errClr2", 1'b0, 1'b0, '0, 1'b1);

        $display("[TB] random traffic with wrap-around");
        for (int i = 0; i < 20; i++)
            applyStimulus("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          DW'($urandom_range(0, 1023)), 1'b0);
        for (int i = 0; i < 2 * DEPTH && cntM != 5; i++) begin
            if (cntM < 5) applyStimulus("to5", 1'b1, 1'b0, DW'($urandom_range(0, 1023)), 1'b0);
            else          applyStimulus("to5", 1'b0, 1'b1, '0, 1'b0);
        end
        checkOutput("reached5", 32'(fillCount), 32'd5);

        $display("[TB] asynchronous reset mid-operation");
        @(negedge clock);
        push = 1'b0;
        pop  = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        resetModel();
        checkState("asyncReset");
        @(negedge clock);
        reset = 1'b0;
        applyStimulus("postReset", 1'b1, 1'b0, 10'h123, 1'b0);
        applyStimulus("postResetPop", 1'b0, 1'b1, '0, 1'b0);

        push = 1'b0;
        pop  = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
